// File: rtl/aes_tcdm_responder_pkg.sv
// Shared types and constants for the multi-bank TCDM responder used as L1 model
// behind the AES HWPE master ports.
package tcdm_responder_package;

    localparam int unsigned N_BANKS_DEF = 4;
    localparam int unsigned DEPTH_DEF   = 256;
    localparam int unsigned BANK_BITS   = $clog2(N_BANKS_DEF);
    localparam int unsigned ROW_BITS    = $clog2(DEPTH_DEF);
    localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_req_t;

endpackage

// File: rtl/aes_tcdm_responder_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// past the winner only when something is granted.
module tcdm_rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Scanning from the far end down lets the candidate nearest the pointer
    // overwrite any later one, so no early exit is needed.
    always_comb begin
        int idx;
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % int'(N);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                ptr_d      = PTR_W'((idx + 1) % int'(N));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/aes_tcdm_responder.sv
// Multi-port, word-interleaved TCDM slave: same-cycle grant per bank, response
// one cycle later, out-of-range accesses answered from a side path.
module aes_tcdm_responder
    import tcdm_responder_package::*;
#(
    parameter int unsigned MP        = 2,
    parameter int unsigned N_BANKS   = N_BANKS_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MP-1:0]        stall_i,
    input  logic [MP-1:0]        tcdm_req,
    output logic [MP-1:0]        tcdm_gnt,
    input  logic [MP-1:0][31:0]  tcdm_add,
    input  logic [MP-1:0]        tcdm_wen,
    input  logic [MP-1:0][3:0]   tcdm_be,
    input  logic [MP-1:0][31:0]  tcdm_data,
    output logic [MP-1:0][31:0]  tcdm_r_data,
    output logic [MP-1:0]        tcdm_r_valid,
    output logic [15:0]          err_cnt_o
);

    // The package widths describe the default build; other sizes derive their own.
    localparam int unsigned BANK_W = (N_BANKS == N_BANKS_DEF) ? BANK_BITS : $clog2(N_BANKS);
    localparam int unsigned ROW_W  = (DEPTH == DEPTH_DEF) ? ROW_BITS : $clog2(DEPTH);
    localparam int unsigned SUM_W  = 16 + $clog2(MP + 1);

    tcdm_req_t               reqs [MP];
    logic [MP-1:0]           inRange;
    logic [BANK_W-1:0]       portBank [MP];
    logic [ROW_W-1:0]        portRow [MP];
    logic [MP-1:0]           activeReq, oobGnt, portGnt;
    logic [N_BANKS-1:0][MP-1:0] bankGntAll;
    logic [31:0]             bankRdata [N_BANKS];

    logic [MP-1:0]           rValid_q, rdIn_q, rdOob_q;
    logic [BANK_W-1:0]       respBank_q [MP];
    logic [15:0]             errCnt_q, errCnt_d;
    logic [SUM_W-1:0]        errSum;

    always_comb begin
        for (int p = 0; p < int'(MP); p++) begin
            reqs[p] = '{add: tcdm_add[p], wen: tcdm_wen[p], be: tcdm_be[p], data: tcdm_data[p]};
        end
    end

    // The row is compared at full width so an address past the top can never alias.
    always_comb begin
        logic [31:0] wordAddr, rowFull;
        wordAddr = '0;
        rowFull  = '0;
        for (int p = 0; p < int'(MP); p++) begin
            wordAddr    = (reqs[p].add - BASE_ADDR) >> 2;
            rowFull     = wordAddr >> BANK_W;
            portBank[p] = wordAddr[BANK_W-1:0];
            portRow[p]  = rowFull[ROW_W-1:0];
            inRange[p]  = (reqs[p].add >= BASE_ADDR) && (rowFull < DEPTH);
        end
    end

    assign activeReq = tcdm_req & ~stall_i & {MP{~rst_i}};
    assign oobGnt    = activeReq & ~inRange;

    for (genvar b = 0; b < int'(N_BANKS); b++) begin : g_bank
        logic [MP-1:0]    bankReq, bankGnt;
        logic             selWen;
        logic [3:0]       selBe;
        logic [31:0]      selData;
        logic [ROW_W-1:0] selRow;
        logic [31:0]      mem_q [DEPTH];
        logic [31:0]      rdData_q;

        always_comb begin
            for (int p = 0; p < int'(MP); p++) begin
                bankReq[p] = activeReq[p] & inRange[p] & (portBank[p] == BANK_W'(b));
            end
        end

        tcdm_rr_arbiter #(.N(MP)) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (bankReq),
            .gnt_o (bankGnt)
        );

        always_comb begin
            selWen  = reqs[0].wen;
            selBe   = reqs[0].be;
            selData = reqs[0].data;
            selRow  = portRow[0];
            for (int p = 0; p < int'(MP); p++) begin
                if (bankGnt[p]) begin
                    selWen  = reqs[p].wen;
                    selBe   = reqs[p].be;
                    selData = reqs[p].data;
                    selRow  = portRow[p];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (|bankGnt) begin
                if (selWen) begin
                    rdData_q <= mem_q[selRow];
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (selBe[i]) begin
                            mem_q[selRow][8*i +: 8] <= selData[8*i +: 8];
                        end
                    end
                end
            end
        end

        assign bankGntAll[b] = bankGnt;
        assign bankRdata[b]  = rdData_q;
    end

    always_comb begin
        portGnt = '0;
        for (int b = 0; b < int'(N_BANKS); b++) begin
            portGnt = portGnt | bankGntAll[b];
        end
    end

    assign tcdm_gnt = portGnt | oobGnt;

    always_comb begin
        errSum = SUM_W'(errCnt_q);
        for (int p = 0; p < int'(MP); p++) begin
            errSum = errSum + SUM_W'(oobGnt[p]);
        end
        errCnt_d = (errSum > SUM_W'(16'hFFFF)) ? 16'hFFFF : errSum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rValid_q <= '0;
            rdIn_q   <= '0;
            rdOob_q  <= '0;
            errCnt_q <= '0;
            for (int p = 0; p < int'(MP); p++) begin
                respBank_q[p] <= '0;
            end
        end else begin
            rValid_q <= tcdm_gnt;
            rdIn_q   <= portGnt & tcdm_wen;
            rdOob_q  <= oobGnt & tcdm_wen;
            errCnt_q <= errCnt_d;
            for (int p = 0; p < int'(MP); p++) begin
                respBank_q[p] <= portBank[p];
            end
        end
    end

    // Write responses and idle cycles carry zero data.
    always_comb begin
        for (int p = 0; p < int'(MP); p++) begin
            tcdm_r_data[p] = '0;
            if (rdOob_q[p]) begin
                tcdm_r_data[p] = ERR_RDATA;
            end else if (rdIn_q[p]) begin
                tcdm_r_data[p] = bankRdata[respBank_q[p]];
            end
        end
    end

    assign tcdm_r_valid = rValid_q;
    assign err_cnt_o    = errCnt_q;

endmodule

// File: tb/tb_aes_tcdm_responder.sv
// Directed bench for aes_tcdm_responder with a word-level memory/arbitration
// model checked every cycle plus hand-computed expectations.
module tb_aes_tcdm_responder;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam longint      BASE_L = 64'h1000_0000;
    localparam longint      SPAN   = 4 * 256 * 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       stall, req, gnt, wen, rvalid;
    logic [1:0][31:0] add, wdata, rdata;
    logic [1:0][3:0]  be;
    logic [15:0]      errCnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] modelMem [longint];
    int          rrPtr [4] = '{0, 0, 0, 0};
    logic [15:0] modelErr = '0;
    logic [1:0]  expValid = '0;
    logic [1:0]  expKnown = '0;
    logic [31:0] expData [2] = '{32'h0, 32'h0};

    always #5 clk = ~clk;

    aes_tcdm_responder dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .tcdm_req     (req),
        .tcdm_gnt     (gnt),
        .tcdm_add     (add),
        .tcdm_wen     (wen),
        .tcdm_be      (be),
        .tcdm_data    (wdata),
        .tcdm_r_data  (rdata),
        .tcdm_r_valid (rvalid),
        .err_cnt_o    (errCnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int p, input logic r, input logic [31:0] a, input logic w,
                                 input logic [3:0] b, input logic [31:0] d);
        req[p]   = r;
        add[p]   = a;
        wen[p]   = w;
        be[p]    = b;
        wdata[p] = d;
    endtask

    task automatic idleAll();
        applyStimulus(0, 1'b0, BASE, 1'b1, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, BASE, 1'b1, 4'h0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: evaluated on the falling edge, when inputs are stable for the coming rising edge.
    always @(negedge clk) begin : compare
        logic [1:0] active, isOob, eGnt;
        longint     off [2];
        int         bank [2];
        int         win, q, nOob;
        logic [31:0] merged;

        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("rvalid%0d", p), 32'(rvalid[p]), 32'(expValid[p]));
            if (expValid[p] && expKnown[p])
                checkOutput($sformatf("rdata%0d", p), rdata[p], expData[p]);
        end
        checkOutput("errcnt", 32'(errCnt), 32'(modelErr));

        eGnt = '0;
        for (int p = 0; p < 2; p++) begin
            off[p]    = longint'(add[p]) - BASE_L;
            isOob[p]  = !(off[p] >= 0 && off[p] < SPAN);
            bank[p]   = isOob[p] ? -1 : int'((off[p] / 4) % 4);
            active[p] = req[p] && !stall[p] && !rst;
            if (active[p] && isOob[p]) eGnt[p] = 1'b1;
        end
        for (int b = 0; b < 4; b++) begin
            win = -1;
            for (int k = 0; k < 2; k++) begin
                q = (rrPtr[b] + k) % 2;
                if (win < 0 && active[q] && !isOob[q] && bank[q] == b) win = q;
            end
            if (win >= 0) begin
                eGnt[win] = 1'b1;
                rrPtr[b]  = (win + 1) % 2;
            end
        end
        checkOutput("gnt", 32'(gnt), 32'(eGnt));

        if (rst) begin
            expValid = '0;
            expKnown = '0;
            modelErr = '0;
            for (int b = 0; b < 4; b++) rrPtr[b] = 0;
        end else begin
            nOob = 0;
            for (int p = 0; p < 2; p++) begin
                expValid[p] = eGnt[p];
                expKnown[p] = 1'b1;
                expData[p]  = 32'h0;
                if (eGnt[p] && isOob[p]) nOob++;
                if (eGnt[p] && wen[p]) begin
                    if (isOob[p]) expData[p] = 32'hDEAD_BEEF;
                    else if (modelMem.exists(off[p] / 4)) expData[p] = modelMem[off[p] / 4];
                    else expKnown[p] = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (eGnt[p] && !wen[p] && !isOob[p]) begin
                    if (modelMem.exists(off[p] / 4) || be[p] == 4'hF) begin
                        merged = modelMem.exists(off[p] / 4) ? modelMem[off[p] / 4] : 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (be[p][i]) merged[8*i +: 8] = wdata[p][8*i +: 8];
                        modelMem[off[p] / 4] = merged;
                    end
                end
            end
            modelErr = (int'(modelErr) + nOob > 65535) ? 16'hFFFF : 16'(int'(modelErr) + nOob);
        end
    end

    initial begin
        int cnt0, cnt1;
        rst   = 1'b1;
        stall = '0;
        idleAll();
        applyStimulus(0, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("reset gnt forced", 32'(gnt), 32'h0);
        checkOutput("reset rvalid", 32'(rvalid), 32'h0);
        checkOutput("reset rdata0", rdata[0], 32'h0);
        checkOutput("reset errcnt", 32'(errCnt), 32'h0);
        nextCycle();
        rst = 1'b0;
        idleAll();
        nextCycle();

        $display("[TB] single-port write/read");
        applyStimulus(0, 1'b1, BASE + 32'h10, 1'b0, 4'hF, 32'hCAFE_BABE);
        @(negedge clk); checkOutput("wr gnt", 32'(gnt), 32'h1);
        nextCycle();
        applyStimulus(0, 1'b1, BASE + 32'h10, 1'b1, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("wr rvalid", 32'(rvalid), 32'h1);
        checkOutput("wr rdata", rdata[0], 32'h0);
        checkOutput("rd gnt", 32'(gnt), 32'h1);
        nextCycle();
        idleAll();
        @(negedge clk);
        checkOutput("rd rvalid", 32'(rvalid), 32'h1);
        checkOutput("rd rdata", rdata[0], 32'hCAFE_BABE);
        nextCycle();

        $display("[TB] byte enables");
        applyStimulus(0, 1'b1, BASE + 32'h20, 1'b0, 4'hF, 32'h1122_3344);
        nextCycle();
        applyStimulus(0, 1'b1, BASE + 32'h20, 1'b0, 4'b0101, 32'hAABB_CCDD);
        nextCycle();
        applyStimulus(0, 1'b1, BASE + 32'h20, 1'b1, 4'h0, 32'h0);
        nextCycle();
        idleAll();
        @(negedge clk); checkOutput("be merge rdata", rdata[0], 32'h11BB_33DD);
        nextCycle();

        $display("[TB] bank conflict");
        applyStimulus(1, 1'b1, BASE, 1'b0, 4'hF, 32'h1234_5678);
        nextCycle();
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                applyStimulus(0, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
                applyStimulus(1, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
            end else begin
                idleAll();
            end
            @(negedge clk);
            if (i > 0) begin
                cnt0 += int'(rvalid[0]);
                cnt1 += int'(rvalid[1]);
            end
            if (i < 4) checkOutput($sformatf("conflict gnt c%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            nextCycle();
        end
        checkOutput("conflict pulses p0", 32'(cnt0), 32'd2);
        checkOutput("conflict pulses p1", 32'(cnt1), 32'd2);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
            applyStimulus(1, 1'b1, BASE + 32'h4, 1'b1, 4'h0, 32'h0);
            @(negedge clk); checkOutput("diff bank gnt", 32'(gnt), 32'h3);
            nextCycle();
        end
        idleAll();
        @(negedge clk); checkOutput("diff bank rdata0", rdata[0], 32'h1234_5678);
        nextCycle();

        $display("[TB] stall");
        stall = 2'b01;
        applyStimulus(0, 1'b1, BASE + 32'h10, 1'b1, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stalled gnt", 32'(gnt), 32'h0);
            checkOutput("stalled rvalid", 32'(rvalid), 32'h0);
            nextCycle();
        end
        stall = 2'b00;
        @(negedge clk); checkOutput("unstalled gnt", 32'(gnt), 32'h1);
        nextCycle();
        idleAll();
        @(negedge clk); checkOutput("unstalled rdata", rdata[0], 32'hCAFE_BABE);
        nextCycle();

        $display("[TB] out of range");
        applyStimulus(0, 1'b1, BASE - 32'h4, 1'b1, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, BASE + 32'h1000, 1'b1, 4'h0, 32'h0);
        @(negedge clk); checkOutput("oob gnt", 32'(gnt), 32'h3);
        nextCycle();
        idleAll();
        applyStimulus(0, 1'b1, BASE + 32'h1010, 1'b0, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("oob rdata0", rdata[0], 32'hDEAD_BEEF);
        checkOutput("oob rdata1", rdata[1], 32'hDEAD_BEEF);
        checkOutput("oob errcnt", 32'(errCnt), 32'd2);
        nextCycle();
        applyStimulus(0, 1'b1, BASE + 32'h10, 1'b1, 4'h0, 32'h0);
        @(negedge clk); checkOutput("oob write errcnt", 32'(errCnt), 32'd3);
        nextCycle();
        idleAll();
        @(negedge clk); checkOutput("oob write no alias", rdata[0], 32'hCAFE_BABE);
        nextCycle();

        $display("[TB] reset mid-flight");
        applyStimulus(0, 1'b1, BASE + 32'h10, 1'b1, 4'h0, 32'h0);
        @(negedge clk); checkOutput("pre-reset gnt", 32'(gnt), 32'h1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
        @(negedge clk); checkOutput("in-reset gnt", 32'(gnt), 32'h0);
        nextCycle();
        rst = 1'b0;
        idleAll();
        @(negedge clk);
        checkOutput("post-reset rvalid", 32'(rvalid), 32'h0);
        checkOutput("post-reset errcnt", 32'(errCnt), 32'h0);
        nextCycle();
        applyStimulus(0, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, BASE, 1'b1, 4'h0, 32'h0);
        @(negedge clk); checkOutput("post-reset rr port0", 32'(gnt), 32'h1);
        nextCycle();
        idleAll();
        nextCycle();

        $display("[TB] error counter saturation");
        applyStimulus(0, 1'b1, BASE - 32'h4, 1'b1, 4'h0, 32'h0);
        applyStimulus(1, 1'b1, BASE + 32'h2000, 1'b1, 4'h0, 32'h0);
        nextCycle();
        @(negedge clk); checkOutput("errcnt first step", 32'(errCnt), 32'd2);
        repeat (32769) nextCycle();
        idleAll();
        @(negedge clk); checkOutput("errcnt saturated", 32'(errCnt), 32'hFFFF);
        nextCycle();
        @(negedge clk); checkOutput("errcnt holds", 32'(errCnt), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
